// File: rtl/obstacle_spawn_scheduler.sv
// obstacle_spawn_scheduler
// Owns three ground-obstacle slots for the runner game. Each live slot walks
// left one pixel per moveClk tick and retires once its right edge has left
// the screen. A countdown gap plus a 16-bit LFSR decide when the next
// obstacle appears and which cactus shape it gets. The block follows the
// game state: idle clears everything, play animates, over freezes the scene.
module obstacle_spawn_scheduler #(
  parameter int          ScreenW = 640,
  parameter int          InitGap = 120,
  parameter int          MinGap  = 200,
  parameter logic [15:0] Seed    = 16'hACE1
) (
  input  logic               moveClk,
  input  logic               rst,
  input  logic [1:0]         gameState,
  output logic signed [10:0] x0,
  output logic signed [10:0] x1,
  output logic signed [10:0] x2,
  output logic [3:0]         sel0,
  output logic [3:0]         sel1,
  output logic [3:0]         sel2,
  output logic [2:0]         active,
  output logic               spawnPulse
);

  // Controller states (legacy-compatible encoding)
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FROZEN = 2'd2;

  // Game state encodings driven by the top-level game FSM
  localparam logic [1:0] GS_IDLE = 2'b00;
  localparam logic [1:0] GS_PLAY = 2'b01;

  localparam int                 NumSlots = 3;
  localparam int                 GapW     = 16;
  localparam logic signed [10:0] ParkX    = 11'(ScreenW);
  localparam logic [GapW-1:0]    InitGapV = GapW'(InitGap);
  localparam logic [GapW-1:0]    MinGapV  = GapW'(MinGap);

  // Shape widths in pixels: three small cacti followed by three large ones.
  function automatic logic [6:0] width_of(input logic [3:0] sel);
    logic [6:0] w;
    case (sel)
      4'd0:    w = 7'd17;
      4'd1:    w = 7'd34;
      4'd2:    w = 7'd51;
      4'd3:    w = 7'd25;
      4'd4:    w = 7'd50;
      4'd5:    w = 7'd75;
      default: w = 7'd0;
    endcase
    return w;
  endfunction

  // Folds the three random bits onto the six legal shapes (6->0, 7->1).
  function automatic logic [3:0] sel_from_bits(input logic [2:0] b);
    logic [2:0] r;
    r = (b >= 3'd6) ? (b - 3'd6) : b;
    return {1'b0, r};
  endfunction

  // True when the slot, after this tick's one-pixel step, is fully off the
  // left edge. Done at 12 bits so newX + width cannot wrap.
  function automatic logic retires(input logic signed [10:0] x,
                                   input logic [3:0]         sel);
    logic signed [11:0] new_x;
    logic signed [11:0] right_edge;
    new_x      = {x[10], x} - 12'sd1;
    right_edge = new_x + $signed({5'b00000, width_of(sel)});
    return (right_edge <= 12'sd0);
  endfunction

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1, shifting left.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  logic [1:0]         state_q, state_d;
  logic [GapW-1:0]    gap_q,   gap_d;
  logic [15:0]        lfsr_q,  lfsr_d;
  logic [2:0]         act_q,   act_d;
  logic               pulse_q, pulse_d;
  logic signed [10:0] x_q   [NumSlots];
  logic signed [10:0] x_d   [NumSlots];
  logic [3:0]         sel_q [NumSlots];
  logic [3:0]         sel_d [NumSlots];

  logic               do_clear;
  logic               do_run;
  logic               spawn_done;
  logic [3:0]         spawn_sel;
  logic [GapW-1:0]    spawn_gap;

  // Shape and follow-up gap a spawn on this tick would use.
  always_comb begin
    spawn_sel = sel_from_bits(lfsr_q[2:0]);
    spawn_gap = MinGapV + {{(GapW-7){1'b0}}, lfsr_q[9:3]};
  end

  // Next-state logic: mode transitions, slot movement/retire and spawning.
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    act_d      = act_q;
    pulse_d    = 1'b0;
    lfsr_d     = lfsr_next(lfsr_q);
    do_clear   = 1'b0;
    do_run     = 1'b0;
    spawn_done = 1'b0;
    for (int i = 0; i < NumSlots; i++) begin
      x_d[i]   = x_q[i];
      sel_d[i] = sel_q[i];
    end

    case (state_q)
      S_IDLE: begin
        do_clear = 1'b1;
        if (gameState == GS_PLAY) state_d = S_RUN;
      end
      S_RUN: begin
        if (gameState == GS_PLAY)      do_run  = 1'b1;
        else if (gameState == GS_IDLE) state_d = S_IDLE;
        else                           state_d = S_FROZEN;
      end
      S_FROZEN: begin
        // Leaving game-over into play wipes the board on this tick and it
        // counts as the first RUN tick, exactly like leaving IDLE.
        if (gameState == GS_IDLE) begin
          state_d = S_IDLE;
        end else if (gameState == GS_PLAY) begin
          do_clear = 1'b1;
          state_d  = S_RUN;
        end
      end
      default: begin
        do_clear = 1'b1;
        state_d  = S_IDLE;
      end
    endcase

    if (do_run) begin
      for (int i = 0; i < NumSlots; i++) begin
        if (act_q[i]) begin
          if (retires(x_q[i], sel_q[i])) begin
            act_d[i] = 1'b0;
            x_d[i]   = ParkX;
          end else begin
            x_d[i] = x_q[i] - 11'sd1;
          end
        end
      end

      // Free-slot search uses act_q, so a slot retiring on this same tick
      // still looks occupied and can only be reused on the next one.
      if (gap_q != '0) begin
        gap_d = gap_q - 1'b1;
      end else begin
        for (int i = 0; i < NumSlots; i++) begin
          if (!act_q[i] && !spawn_done) begin
            act_d[i]   = 1'b1;
            x_d[i]     = ParkX;
            sel_d[i]   = spawn_sel;
            spawn_done = 1'b1;
          end
        end
        if (spawn_done) begin
          gap_d   = spawn_gap;
          pulse_d = 1'b1;
        end
      end
    end

    if (do_clear) begin
      act_d = '0;
      gap_d = InitGapV;
      for (int i = 0; i < NumSlots; i++) begin
        x_d[i]   = ParkX;
        sel_d[i] = '0;
      end
    end
  end

  // State registers; reset parks every slot off-screen and reloads the LFSR.
  always_ff @(posedge moveClk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gap_q   <= InitGapV;
      lfsr_q  <= Seed;
      act_q   <= '0;
      pulse_q <= 1'b0;
      for (int i = 0; i < NumSlots; i++) begin
        x_q[i]   <= ParkX;
        sel_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      lfsr_q  <= lfsr_d;
      act_q   <= act_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NumSlots; i++) begin
        x_q[i]   <= x_d[i];
        sel_q[i] <= sel_d[i];
      end
    end
  end

  assign x0         = x_q[0];
  assign x1         = x_q[1];
  assign x2         = x_q[2];
  assign sel0       = sel_q[0];
  assign sel1       = sel_q[1];
  assign sel2       = sel_q[2];
  assign active     = act_q;
  assign spawnPulse = pulse_q;

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// Directed bench for obstacle_spawn_scheduler.
// Three instances share moveClk:
//   u_a  : default parameters; first spawn timing, freeze/clear, async reset.
//   u_b6 : Seed 0x0003, InitGap 0, MinGap 4; first spawn sees lfsr[2:0]=6,
//          fills all slots quickly, then exercises retire and slot reuse.
//   u_b7 : Seed 0x8003, InitGap 0; first spawn sees lfsr[2:0]=7 (sel 1).
module tb_obstacle_spawn_scheduler;

  localparam int PARK = 640;

  logic       moveClk = 1'b0;
  logic       rst_a, rst_b;
  logic [1:0] gs_a, gs_b;

  logic signed [10:0] a_x0, a_x1, a_x2, b6_x0, b6_x1, b6_x2, b7_x0, b7_x1, b7_x2;
  logic [3:0] a_sel0, a_sel1, a_sel2, b6_sel0, b6_sel1, b6_sel2, b7_sel0, b7_sel1, b7_sel2;
  logic [2:0] a_act, b6_act, b7_act;
  logic       a_sp, b6_sp, b7_sp;

  int n_checks = 0;
  int n_pass   = 0;
  int ec       = 0;
  int full_bad = 0;
  int frz_bad  = 0;
  int exp_sel_a1, exp_sel_a2;

  always #5 moveClk = ~moveClk;

  obstacle_spawn_scheduler u_a (
    .moveClk(moveClk), .rst(rst_a), .gameState(gs_a),
    .x0(a_x0), .x1(a_x1), .x2(a_x2),
    .sel0(a_sel0), .sel1(a_sel1), .sel2(a_sel2),
    .active(a_act), .spawnPulse(a_sp)
  );

  obstacle_spawn_scheduler #(.InitGap(0), .MinGap(4), .Seed(16'h0003)) u_b6 (
    .moveClk(moveClk), .rst(rst_b), .gameState(gs_b),
    .x0(b6_x0), .x1(b6_x1), .x2(b6_x2),
    .sel0(b6_sel0), .sel1(b6_sel1), .sel2(b6_sel2),
    .active(b6_act), .spawnPulse(b6_sp)
  );

  obstacle_spawn_scheduler #(.InitGap(0), .Seed(16'h8003)) u_b7 (
    .moveClk(moveClk), .rst(rst_b), .gameState(gs_b),
    .x0(b7_x0), .x1(b7_x1), .x2(b7_x2),
    .sel0(b7_sel0), .sel1(b7_sel1), .sel2(b7_sel2),
    .active(b7_act), .spawnPulse(b7_sp)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference LFSR: x^16+x^14+x^13+x^11+1, left shift, n steps.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] s, input int n);
    logic [15:0] v;
    v = s;
    for (int k = 0; k < n; k++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return v;
  endfunction

  function automatic int map_sel(input logic [15:0] v);
    int b;
    b = int'(v[2:0]);
    return (b >= 6) ? b - 6 : b;
  endfunction

  task automatic tick();
    @(posedge moveClk);
    #1;
    ec++;
  endtask

  initial begin
    // Edge E (1-based after reset release) spawns with lfsr = Seed advanced E-1 times.
    exp_sel_a1 = map_sel(lfsr_adv(16'hACE1, 121));
    exp_sel_a2 = map_sel(lfsr_adv(16'hACE1, 311));

    rst_a = 1'b1; rst_b = 1'b1;
    gs_a  = 2'b01; gs_b = 2'b01;
    #1;
    check_val("rst_x0",     a_x0,   PARK);
    check_val("rst_x1",     a_x1,   PARK);
    check_val("rst_x2",     a_x2,   PARK);
    check_val("rst_sel0",   a_sel0, 0);
    check_val("rst_active", a_act,  0);
    check_val("rst_pulse",  a_sp,   0);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;

    for (int e = 1; e <= 676; e++) begin
      tick();
      // ---- default instance: entry, first spawn, freeze, clear, respawn
      if (ec == 1) begin
        check_val("a_enter_active", a_act, 0);
        check_val("a_enter_pulse",  a_sp,  0);
      end
      if (ec == 121) check_val("a_e121_pulse", a_sp, 0);
      if (ec == 122) begin
        check_val("a_spawn_pulse",  a_sp,   1);
        check_val("a_spawn_active", a_act,  1);
        check_val("a_spawn_x0",     a_x0,   PARK);
        check_val("a_spawn_sel0",   a_sel0, exp_sel_a1);
      end
      if (ec == 123) begin
        check_val("a_move_x0",    a_x0, 639);
        check_val("a_move_pulse", a_sp, 0);
      end
      if (ec == 140) begin
        check_val("a_prefrz_x0", a_x0, 622);
        gs_a = 2'b10;
      end
      if (ec >= 141 && ec <= 190) begin
        if (a_x0 != 11'sd622 || a_act != 3'b001 || int'(a_sel0) != exp_sel_a1 ||
            a_x1 != 11'sd640 || a_sp != 1'b0) frz_bad++;
      end
      if (ec == 190) begin
        check_val("a_frozen_ticks_bad", frz_bad, 0);
        check_val("a_frozen_x0",        a_x0,    622);
        gs_a = 2'b01;
      end
      if (ec == 191) begin
        check_val("a_clear_active", a_act,  0);
        check_val("a_clear_x0",     a_x0,   PARK);
        check_val("a_clear_sel0",   a_sel0, 0);
        check_val("a_clear_pulse",  a_sp,   0);
      end
      if (ec == 311) begin
        check_val("a_e311_pulse",  a_sp,  0);
        check_val("a_e311_active", a_act, 0);
      end
      if (ec == 312) begin
        check_val("a_respawn_pulse",  a_sp,   1);
        check_val("a_respawn_active", a_act,  1);
        check_val("a_respawn_sel0",   a_sel0, exp_sel_a2);
      end
      if (ec == 315) check_val("a_respawn_x0", a_x0, 637);

      // ---- lfsr[2:0]=6 / 7 shape fold and width-dependent retire
      if (ec == 2) begin
        check_val("b6_spawn_pulse",  b6_sp,   1);
        check_val("b6_spawn_active", b6_act,  1);
        check_val("b6_spawn_sel6",   b6_sel0, 0);
        check_val("b6_spawn_x0",     b6_x0,   PARK);
        check_val("b7_spawn_pulse",  b7_sp,   1);
        check_val("b7_spawn_sel7",   b7_sel0, 1);
        check_val("b7_spawn_x0",     b7_x0,   PARK);
      end
      if (ec == 3) check_val("b6_move_x0", b6_x0, 639);
      if (ec == 7) begin
        check_val("b6_spawn2_pulse",  b6_sp,   1);
        check_val("b6_spawn2_active", b6_act,  3);
        check_val("b6_spawn2_x1",     b6_x1,   PARK);
        check_val("b6_spawn2_sel1",   b6_sel1, 0);
      end
      if (ec == 35) begin
        check_val("b6_e35_pulse",  b6_sp,  0);
        check_val("b6_e35_active", b6_act, 3);
      end
      if (ec == 36) begin
        check_val("b6_spawn3_pulse",  b6_sp,  1);
        check_val("b6_spawn3_active", b6_act, 7);
        check_val("b6_spawn3_x2",     b6_x2,  PARK);
      end
      if (ec >= 37 && ec <= 658) begin
        if (b6_sp != 1'b0 || b6_act != 3'b111) full_bad++;
      end
      if (ec == 658) begin
        check_val("b6_full_no_spawn", full_bad, 0);
        check_val("b6_last_x0",       b6_x0,    -16);
      end
      if (ec == 659) begin
        check_val("b6_retire_active", b6_act, 6);
        check_val("b6_retire_x0",     b6_x0,  PARK);
        check_val("b6_retire_pulse",  b6_sp,  0);
      end
      if (ec == 660) begin
        check_val("b6_reuse_pulse",  b6_sp,  1);
        check_val("b6_reuse_active", b6_act, 7);
        check_val("b6_reuse_x0",     b6_x0,  PARK);
      end
      if (ec == 663) check_val("b6_last_x1", b6_x1, -16);
      if (ec == 664) begin
        check_val("b6_retire1_act", int'(b6_act[1]), 0);
        check_val("b6_retire1_x1",  b6_x1,           PARK);
      end
      if (ec == 675) check_val("b7_last_x0", b7_x0, -33);
      if (ec == 676) begin
        check_val("b7_retire_x0",    b7_x0,            PARK);
        check_val("b7_retire_act0",  int'(b7_act[0]),  0);
        check_val("b6_two_live",     int'(b6_act & 3'b101), 5);
      end
    end

    // Asynchronous reset between edges with slots live.
    #2;
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    check_val("arst_b6_active", b6_act,  0);
    check_val("arst_b6_x0",     b6_x0,   PARK);
    check_val("arst_b6_x2",     b6_x2,   PARK);
    check_val("arst_b6_sel0",   b6_sel0, 0);
    check_val("arst_b6_pulse",  b6_sp,   0);
    check_val("arst_a_active",  a_act,   0);
    check_val("arst_a_x0",      a_x0,    PARK);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // Restart from reset: transition edge, then spawn with the reloaded seed.
    tick();
    check_val("rerun_e1_active", b6_act, 0);
    tick();
    check_val("rerun_b6_pulse", b6_sp,   1);
    check_val("rerun_b6_sel0",  b6_sel0, 0);
    check_val("rerun_b7_sel0",  b7_sel0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
